load_store_unit: RTL

Sequences load/store requests from the execute stage into the byte-addressed data memory, which has a one-cycle registered read. Computes the effective address and rejects misaligned, out-of-range and illegal-funct3 accesses before they reach memory. Drives the memory port with registered, one-cycle strobes. Returns a load result or completion status to writeback over a valid/ready handshake.

---
 rtl/load_store_unit.sv | 144 ++++++++++++++
 1 files changed

// File: rtl/load_store_unit.sv
// Load/store sequencer between execute and a byte-addressed data memory.
// Screens each request for faults, strobes memory once, returns one response.
module load_store_unit #(
  parameter int MEMSIZE = 64
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_load,
  input  logic        req_store,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_base,
  input  logic [31:0] req_offset,
  input  logic [31:0] req_wdata,
  input  logic [4:0]  req_rd,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_value,
  output logic [2:0]  mem_funct3,
  output logic        mem_read,
  output logic        mem_write,
  input  logic [31:0] mem_data,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [4:0]  resp_rd,
  output logic        resp_we,
  output logic [31:0] resp_data,
  output logic        resp_fault
);

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    RESP
  } state_t;

  state_t      state;
  logic        is_load;
  logic [4:0]  rd_q;

  logic [31:0] ea;
  logic        ld_op;
  logic        st_op;
  logic        bad_op;
  logic        bad_f3;
  logic        misal;
  logic        oob;
  logic        fault;
  logic [2:0]  size;
  logic [32:0] last;

  always_comb begin
    ea     = req_base + req_offset;
    ld_op  = req_load & ~req_store;
    st_op  = req_store & ~req_load;
    bad_op = ~(ld_op | st_op);
    case (req_funct3[1:0])
      2'd0:    size = 3'd1;
      2'd1:    size = 3'd2;
      default: size = 3'd4;
    endcase
    bad_f3 = (ld_op && (req_funct3 == 3'd3 ||
                        req_funct3[2:1] == 2'b11)) ||
             (st_op && req_funct3 > 3'd2);
    misal  = (req_funct3[1:0] == 2'd1 && ea[0]) ||
             (req_funct3[1:0] == 2'd2 && ea[1:0] != 2'd0);
    // 33-bit sum so an address that wraps past 2^32 still reads as too high
    last   = {1'b0, ea} + {30'b0, size} - 33'd1;
    oob    = last > 33'(MEMSIZE - 1);
    fault  = bad_op | bad_f3 | misal | oob;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      is_load    <= 1'b0;
      rd_q       <= 5'd0;
      req_ready  <= 1'b1;
      mem_addr   <= 32'd0;
      mem_value  <= 32'd0;
      mem_funct3 <= 3'd0;
      mem_read   <= 1'b0;
      mem_write  <= 1'b0;
      resp_valid <= 1'b0;
      resp_rd    <= 5'd0;
      resp_we    <= 1'b0;
      resp_data  <= 32'd0;
      resp_fault <= 1'b0;
    end else begin
      mem_read  <= 1'b0;
      mem_write <= 1'b0;
      unique case (state)
        IDLE: begin
          if (req_valid) begin
            req_ready <= 1'b0;
            rd_q      <= req_rd;
            is_load   <= ld_op;
            if (fault) begin
              state      <= RESP;
              resp_valid <= 1'b1;
              resp_fault <= 1'b1;
            end else begin
              state      <= ISSUE;
              mem_addr   <= ea;
              mem_funct3 <= req_funct3;
              mem_value  <= req_wdata;
              mem_read   <= ld_op;
              mem_write  <= st_op;
            end
          end
        end
        ISSUE: begin
          if (is_load) begin
            state <= WAIT;
          end else begin
            state      <= RESP;
            resp_valid <= 1'b1;
          end
        end
        WAIT: begin
          state      <= RESP;
          resp_valid <= 1'b1;
          resp_data  <= mem_data;
          resp_rd    <= rd_q;
          resp_we    <= rd_q != 5'd0;
        end
        RESP: begin
          if (resp_ready) begin
            state      <= IDLE;
            req_ready  <= 1'b1;
            resp_valid <= 1'b0;
            resp_rd    <= 5'd0;
            resp_we    <= 1'b0;
            resp_data  <= 32'd0;
            resp_fault <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
